// File: rtl/memory_game_pkg.sv
`default_nettype none
// ============================================================================
// memory_game_pkg : shared FSM states and display codes for the memory game
// Revision 1.0
// ============================================================================
package memory_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHOW   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESULT = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    localparam logic [1:0] DS_PLAY = 2'd0;
    localparam logic [1:0] DS_OK   = 2'd1;
    localparam logic [1:0] DS_BAD  = 2'd2;
    localparam logic [1:0] DS_OVER = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_game_core_tick_timer.sv
`default_nettype none
// ============================================================================
// tick_timer : counts game ticks up to a variable limit, flags done on reach
// Revision 1.0
// ============================================================================
module tick_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign done = (count_q == limit);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && !done) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_game_core.sv
`default_nettype none
// ============================================================================
// memory_game_core : LED memory game engine (show, wait, score, lives, level)
// Revision 1.0
// ============================================================================
module memory_game_core
    import memory_game_pkg::*;
#(
    parameter int N_LEDS       = 10,
    parameter int MAX_LEVEL    = 8,
    parameter int LIVES        = 3,
    parameter int RESULT_TICKS = 2,
    parameter int SCORE_W      = 8
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic                             tick,
    input  logic                             start,
    input  logic                             submit,
    input  logic [N_LEDS-1:0]                sw,
    input  logic [N_LEDS-1:0]                rand_value,
    output logic [N_LEDS-1:0]                led,
    output logic [1:0]                       display_state,
    output logic [SCORE_W-1:0]               score,
    output logic [$clog2(MAX_LEVEL+1)-1:0]   level,
    output logic [$clog2(LIVES+1)-1:0]       lives,
    output logic                             inc_point,
    output logic                             dec_point
);

    localparam int LVL_W = $clog2(MAX_LEVEL + 1);
    localparam int LIV_W = $clog2(LIVES + 1);
    localparam int TMR_W = $clog2(max_int(MAX_LEVEL, RESULT_TICKS) + 1);

    state_t              state_q, state_d;
    logic [N_LEDS-1:0]   pattern_q, pattern_d;
    logic [N_LEDS-1:0]   led_q, led_d;
    logic [1:0]          ds_q, ds_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [LIV_W-1:0]    lives_q, lives_d;
    logic                inc_q, inc_d;
    logic                dec_q, dec_d;

    logic [N_LEDS-1:0]   captured;
    logic                timer_clear;
    logic                timer_tick;
    logic                timer_done;
    logic [TMR_W-1:0]    timer_limit;

    // An all-zero draw would show nothing, so it is replaced by LED0 alone.
    assign captured = (rand_value == '0) ? N_LEDS'(1) : rand_value;

    assign timer_tick  = tick && ((state_q == ST_SHOW) || (state_q == ST_RESULT));
    assign timer_limit = (state_q == ST_SHOW) ? TMR_W'(MAX_LEVEL + 1 - int'(level_q))
                                              : TMR_W'(RESULT_TICKS);

    tick_timer #(
        .W (TMR_W)
    ) u_timer (
        .clock  (clock),
        .resetn (resetn),
        .clear  (timer_clear),
        .tick   (timer_tick),
        .limit  (timer_limit),
        .done   (timer_done)
    );

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        led_d       = led_q;
        ds_d        = ds_q;
        score_d     = score_q;
        level_d     = level_q;
        lives_d     = lives_q;
        inc_d       = 1'b0;
        dec_d       = 1'b0;
        timer_clear = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                led_d = '0;
                if (start) begin
                    state_d     = ST_SHOW;
                    score_d     = '0;
                    level_d     = LVL_W'(1);
                    lives_d     = LIV_W'(LIVES);
                    pattern_d   = captured;
                    led_d       = captured;
                    ds_d        = DS_PLAY;
                    timer_clear = 1'b1;
                end
            end
            ST_SHOW: begin
                led_d = pattern_q;
                if (timer_done) begin
                    state_d = ST_WAIT;
                    led_d   = '0;
                end
            end
            ST_WAIT: begin
                led_d = '0;
                if (submit) begin
                    state_d     = ST_RESULT;
                    timer_clear = 1'b1;
                    if (sw == pattern_q) begin
                        score_d = (score_q == '1) ? score_q : score_q + 1'b1;
                        level_d = (level_q == LVL_W'(MAX_LEVEL)) ? level_q : level_q + 1'b1;
                        inc_d   = 1'b1;
                        ds_d    = DS_OK;
                    end else begin
                        lives_d = lives_q - 1'b1;
                        dec_d   = 1'b1;
                        ds_d    = DS_BAD;
                    end
                end
            end
            ST_RESULT: begin
                led_d = '0;
                if (timer_done) begin
                    if (lives_q == '0) begin
                        state_d = ST_OVER;
                        ds_d    = DS_OVER;
                        led_d   = '1;
                    end else begin
                        state_d     = ST_SHOW;
                        pattern_d   = captured;
                        led_d       = captured;
                        ds_d        = DS_PLAY;
                        timer_clear = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (tick) begin
                    led_d = ~led_q;
                end
                if (start) begin
                    state_d     = ST_SHOW;
                    score_d     = '0;
                    level_d     = LVL_W'(1);
                    lives_d     = LIV_W'(LIVES);
                    pattern_d   = captured;
                    led_d       = captured;
                    ds_d        = DS_PLAY;
                    timer_clear = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            led_q     <= '0;
            ds_q      <= DS_PLAY;
            score_q   <= '0;
            level_q   <= LVL_W'(1);
            lives_q   <= LIV_W'(LIVES);
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            led_q     <= led_d;
            ds_q      <= ds_d;
            score_q   <= score_d;
            level_q   <= level_d;
            lives_q   <= lives_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
        end
    end

    assign led           = led_q;
    assign display_state = ds_q;
    assign score         = score_q;
    assign level         = level_q;
    assign lives         = lives_q;
    assign inc_point     = inc_q;
    assign dec_point     = dec_q;

endmodule
`default_nettype wire

// File: doc/memory_game_core.md
Name: memory_game_core

Overview:
- Parametrised game engine for the LED memory game.
- Flashes a random LED pattern for a level-dependent time, blanks it, waits for the player to set the switches and press submit, then scores the attempt.
- Tracks score, level and lives.
- Sits between the random generator and clock divider (upstream) and the 7-segment display controller (downstream), replacing the separate start/input blocks.

Parameters:
- N_LEDS, 10, width of pattern, switches and LEDs.
- MAX_LEVEL, 8, highest level; level range 1..MAX_LEVEL.
- LIVES, 3, wrong answers allowed before game over (≥1).
- RESULT_TICKS, 2, game ticks that a correct/wrong verdict is shown.
- SCORE_W, 8, score counter width.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- tick  in  1  single-cycle game-tick enable (from clock divider).
- start  in  1  single-cycle pulse, already synchronised/debounced (key[3]).
- submit  in  1  single-cycle pulse, already synchronised/debounced (key[2]).
- sw  in  N_LEDS  player guess.
- rand  in  N_LEDS  free-running random value.
- led  out  N_LEDS  displayed pattern.
- display_state  out  2  0=idle/playing, 1=correct, 2=wrong, 3=game over.
- score  out  SCORE_W  correct answers this game.
- level  out  clog2(MAX_LEVEL+1)  current level.
- lives  out  clog2(LIVES+1)  remaining lives.
- inc_point  out  1  one-cycle pulse on a correct answer.
- dec_point  out  1  one-cycle pulse on a wrong answer.

Behaviour:
- Reset (async, resetn=0) values:
  - state=IDLE, led=0, display_state=0, score=0, level=1, lives=LIVES.
  - inc_point=0, dec_point=0, pattern=0, timer=0.
- All outputs are registered.
- FSM states: IDLE, SHOW, WAIT, RESULT, OVER.
- IDLE:
  - led=0.
  - start → SHOW: load score=0, level=1, lives=LIVES; capture pattern; timer=0.
- Pattern capture (every entry to SHOW):
  - pattern = rand.
  - If rand==0, pattern = 1 (LED0), so the pattern is never empty.
- SHOW:
  - led=pattern.
  - timer counts tick pulses only.
  - When timer reaches show_len = MAX_LEVEL+1−level, go to WAIT; led=0 from the next cycle.
  - submit and start are ignored.
- WAIT:
  - led=0; no timeout.
  - On submit, compare sw with pattern:
    - Equal: score+1 (saturates at 2^SCORE_W−1); level+1 (saturates at MAX_LEVEL); inc_point=1 for exactly one cycle; display_state=1.
    - Not equal: lives−1; dec_point=1 for exactly one cycle; display_state=2.
  - In both cases go to RESULT with timer=0.
  - The update and pulse appear in the cycle immediately after the clock edge that samples submit=1. Latency is 1 cycle.
- RESULT:
  - led=0.
  - After RESULT_TICKS ticks:
    - lives==0 → OVER, display_state=3.
    - Otherwise → SHOW with a new pattern captured, display_state=0.
- OVER:
  - led = all ones, blinking: toggles on every tick.
  - score, level and lives hold.
  - start → same as start from IDLE (new game).
- Input priority:
  - start outside IDLE/OVER is ignored.
  - start and submit in the same cycle: only the one legal in the current state acts.
  - tick coincident with submit in WAIT: submit acts; tick is irrelevant in WAIT.
  - Only one pulse per submit, even if submit is held (pulse input assumed; level-held submit is an input-protocol violation).
- Reset mid-operation: everything returns to the reset values; inc_point/dec_point deassert immediately.

Decomposition:
- Shared package memory_game_pkg holds:
  - FSM state encoding constants.
  - display_state codes: DS_PLAY=0, DS_OK=1, DS_BAD=2, DS_OVER=3.
- One sub-module: tick_timer.
  - Counts tick pulses.
  - Synchronous clear; compare against a variable limit; asserts done.
  - Used by both SHOW and RESULT.

Test Plan:
All scenarios use N_LEDS=10, MAX_LEVEL=4, LIVES=3, RESULT_TICKS=2, SCORE_W=8.

1. Reset then start with rand=10'h2A5 → led=10'h2A5 for exactly 4 ticks, then led=0; level=1, lives=3, score=0.
2. In WAIT, sw=10'h2A5 and submit → next cycle inc_point=1 for one cycle; score=1, level=2, display_state=1; after 2 ticks the next SHOW lasts 3 ticks.
3. Wrong guess sw=10'h000 three times → dec_point pulses each time; lives 3→2→1→0; after the third RESULT, display_state=3 and led blinks 10'h3FF/0 each tick; start then restarts with score=0, lives=3.
4. rand=0 at capture → pattern=10'h001; submit with sw=10'h001 is scored correct.
5. Five consecutive correct answers → level saturates at 4 (show_len=1); score=5; start and submit pulses during SHOW change nothing.
6. resetn driven low mid-RESULT, coincident with an inc_point pulse → all outputs take reset values asynchronously; no further pulses appear.
